// File: rtl/mem_cmd_master.sv
// Byte-stream command master: receives a read/write frame, issues one bus
// operation, waits for the responder and streams back read data or a status byte.
module mem_cmd_master #(
  parameter logic [7:0] CMD_READ       = 8'h52,
  parameter logic [7:0] CMD_WRITE      = 8'h57,
  parameter logic [7:0] RSP_ACK        = 8'h06,
  parameter logic [7:0] RSP_NAK        = 8'h15,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_rdy,
  output logic [1:0]  o_mem_op,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_data,
  input  logic [63:0] i_mem_data,
  input  logic        i_mem_op_pending,
  output logic        o_busy
);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam int            WW        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, ISSUE, WAIT, TX_DATA, TX_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    op_q;
  logic [2:0]    cnt;
  logic [2:0]    cnt_inc;
  logic [WW-1:0] wait_cnt;
  logic [63:0]   cap;
  logic          is_cmd;
  logic          tx_fire;
  logic          timeout;

  assign cnt_inc = cnt + 3'd1;
  assign is_cmd  = (i_rx_data == CMD_READ) || (i_rx_data == CMD_WRITE);
  assign tx_fire = o_tx_valid && i_tx_rdy;
  assign timeout = i_mem_op_pending && (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_mem_op  = OP_NOP;
    o_busy    = (state != IDLE);
    case (state)
      IDLE:    if (i_rx_valid) state_nxt = is_cmd ? RX_ADDR : TX_RESP;
      RX_ADDR: if (i_rx_valid && cnt == 3'd7)
                 state_nxt = (op_q == OP_WRITE) ? RX_DATA : ISSUE;
      RX_DATA: if (i_rx_valid && cnt == 3'd7) state_nxt = ISSUE;
      ISSUE: begin
        o_mem_op  = op_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!i_mem_op_pending) state_nxt = (op_q == OP_READ) ? TX_DATA : TX_RESP;
        else if (timeout)      state_nxt = TX_RESP;
      end
      TX_DATA: if (tx_fire && cnt == 3'd7) state_nxt = IDLE;
      TX_RESP: if (tx_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are written only while receiving, so they stay stable from ISSUE to IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q       <= OP_NOP;
      cnt        <= 3'd0;
      wait_cnt   <= '0;
      cap        <= 64'd0;
      o_mem_addr <= 64'd0;
      o_mem_data <= 64'd0;
      o_tx_data  <= 8'd0;
      o_tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (i_rx_valid) begin
            if (is_cmd) begin
              op_q <= (i_rx_data == CMD_READ) ? OP_READ : OP_WRITE;
            end else begin
              o_tx_data  <= RSP_NAK;
              o_tx_valid <= 1'b1;
            end
          end
        end
        RX_ADDR: if (i_rx_valid) begin
          o_mem_addr[{cnt, 3'b000} +: 8] <= i_rx_data;
          cnt <= cnt_inc;
        end
        RX_DATA: if (i_rx_valid) begin
          o_mem_data[{cnt, 3'b000} +: 8] <= i_rx_data;
          cnt <= cnt_inc;
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (!i_mem_op_pending) begin
            o_tx_valid <= 1'b1;
            cnt        <= 3'd0;
            if (op_q == OP_READ) begin
              cap       <= i_mem_data;
              o_tx_data <= i_mem_data[7:0];
            end else begin
              o_tx_data <= RSP_ACK;
            end
          end else if (timeout) begin
            o_tx_data  <= RSP_NAK;
            o_tx_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        TX_DATA: if (tx_fire) begin
          cnt <= cnt_inc;
          if (cnt == 3'd7) o_tx_valid <= 1'b0;
          else             o_tx_data  <= cap[{cnt_inc, 3'b000} +: 8];
        end
        TX_RESP: if (tx_fire) o_tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_master.sv
// Randomised scoreboard bench for mem_cmd_master: expected bus ops and reply
// bytes are queued at stimulus time and checked by a free-running monitor.
module tb_mem_cmd_master;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_rdy = 1'b1;
  logic [1:0]  o_mem_op;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_data;
  logic [63:0] i_mem_data = 64'd0;
  logic        i_mem_op_pending = 1'b0;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_rdy(i_tx_rdy),
    .o_mem_op(o_mem_op), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_op_pending(i_mem_op_pending),
    .o_busy(o_busy)
  );

  typedef struct { logic [7:0] b; int lat; logic has_bus; logic [63:0] addr; } exp_t;
  typedef struct { logic [1:0] op; logic [63:0] addr; logic [63:0] data; } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int wk = 1000000;
  int issue_cnt = 0;
  int delay = 0;
  bit forever_pend = 1'b0;
  int rdy_mode = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Transmitter ready pattern: always, one-in-three, or random.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       i_tx_rdy = 1'b1;
      1:       i_tx_rdy = (cyc % 3 == 0);
      default: i_tx_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Responder model plus TX monitor; wk counts cycles since the last bus op.
  logic       prev_op_nz = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  int         first_lat  = -1;

  always @(negedge clk) begin
    bus_t b;
    exp_t e;
    wk++;
    if (o_mem_op != 2'd0) begin
      checkOutput("op_one_cycle", 64'(prev_op_nz), 64'd0);
      if (bus_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_op: actual %0d required none", o_mem_op);
      end else begin
        b = bus_q.pop_front();
        checkOutput("bus_op", 64'(o_mem_op), 64'(b.op));
        checkOutput("bus_addr", o_mem_addr, b.addr);
        if (b.op == 2'd2) checkOutput("bus_wdata", o_mem_data, b.data);
      end
      wk = 0;
      issue_cnt++;
    end
    prev_op_nz = (o_mem_op != 2'd0);
    i_mem_op_pending = (wk >= 1) && (forever_pend || wk <= delay);

    if (prev_stall) begin
      checkOutput("tx_hold_valid", 64'(o_tx_valid), 64'd1);
      checkOutput("tx_hold_data", 64'(o_tx_data), 64'(prev_data));
    end
    if (o_tx_valid && !prev_valid) first_lat = wk;
    if (o_tx_valid && i_tx_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_tx: actual %0h required none", o_tx_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("tx_byte", 64'(o_tx_data), 64'(e.b));
        if (e.lat >= 0) checkOutput("tx_latency", 64'(first_lat), 64'(e.lat));
        if (e.has_bus) checkOutput("addr_stable", o_mem_addr, e.addr);
      end
    end
    prev_stall = o_tx_valid && !i_tx_rdy;
    prev_valid = o_tx_valid;
    prev_data  = o_tx_data;
  end

  task automatic sendByte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  // Waits for the block to go idle; optionally throws junk bytes in while it is in WAIT.
  task automatic waitIdle(input bit junk, input int ic, input int lim);
    int n = 0;
    while (o_busy && n < T + 200) begin
      if (junk && issue_cnt != ic && wk + 1 <= lim) begin
        i_rx_valid = 1'b1;
        i_rx_data  = 8'($urandom);
      end else begin
        i_rx_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    i_rx_valid = 1'b0;
    checkOutput("done_in_budget", 64'(o_busy), 64'd0);
  endtask

  // kind: 0 write, 1 read, 2 bad command (cmd = wdata[7:0]), 3 read that times out
  task automatic applyStimulus(input int kind, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdata,
                               input int dly);
    logic [7:0] frame[$];
    int ic;
    int lim;
    delay        = dly;
    forever_pend = (kind == 3);
    i_mem_data   = rdata;
    lim          = (kind == 3) ? T : dly + 1;
    case (kind)
      0: begin
        bus_q.push_back('{2'd2, addr, wdata});
        exp_q.push_back('{8'h06, dly + 2, 1'b1, addr});
        frame.push_back(8'h57);
      end
      1: begin
        bus_q.push_back('{2'd1, addr, 64'd0});
        for (int k = 0; k < 8; k++)
          exp_q.push_back('{rdata[8*k +: 8], (k == 0) ? dly + 2 : -1, 1'b1, addr});
        frame.push_back(8'h52);
      end
      2: begin
        exp_q.push_back('{8'h15, -1, 1'b0, 64'd0});
        frame.push_back(wdata[7:0]);
      end
      default: begin
        bus_q.push_back('{2'd1, addr, 64'd0});
        exp_q.push_back('{8'h15, T + 1, 1'b1, addr});
        frame.push_back(8'h52);
      end
    endcase
    if (kind != 2) for (int k = 0; k < 8; k++) frame.push_back(addr[8*k +: 8]);
    if (kind == 0) for (int k = 0; k < 8; k++) frame.push_back(wdata[8*k +: 8]);
    ic = issue_cnt;
    foreach (frame[k]) sendByte(frame[k]);
    waitIdle((kind == 3) || (kind != 2 && dly >= 2), ic, lim);
    forever_pend = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_op"}, 64'(o_mem_op), 64'd0);
    checkOutput({tag, "_mem_addr"}, o_mem_addr, 64'd0);
    checkOutput({tag, "_mem_data"}, o_mem_data, 64'd0);
    checkOutput({tag, "_tx_data"}, 64'(o_tx_data), 64'd0);
    checkOutput({tag, "_tx_valid"}, 64'(o_tx_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [7:0] bad;
    int kind;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 64'h10, 64'h1122334455667788, 64'd0, 0);
    applyStimulus(1, 64'h10, 64'd0, 64'h1122334455667788, 2);
    applyStimulus(2, 64'd0, 64'h41, 64'd0, 0);
    applyStimulus(3, {$urandom, $urandom}, 64'd0, {$urandom, $urandom}, 0);
    rdy_mode = 1;
    applyStimulus(1, {$urandom, $urandom}, 64'd0, {$urandom, $urandom}, 3);

    // Abort a write frame after the fourth address byte, then run a clean write.
    rdy_mode = 0;
    sendByte(8'h57);
    for (int k = 0; k < 4; k++) sendByte(8'($urandom));
    i_rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midreset");
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1);

    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      kind = (i % 10 == 9) ? 3 : int'($urandom_range(0, 2));
      do bad = 8'($urandom); while (bad == 8'h52 || bad == 8'h57);
      applyStimulus(kind, {$urandom, $urandom}, {$urandom, $urandom[31:8], bad},
                    {$urandom, $urandom}, int'($urandom_range(0, 5)));
    end

    repeat (4) @(posedge clk);
    checkOutput("exp_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("bus_drained", 64'(bus_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_cmd_master.md
MEM_CMD_MASTER -- requirements
Module: mem_cmd_master

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'h52, command byte that selects a read.
REQ-002 SHALL have parameter CMD_WRITE, default 8'h57, command byte that selects a write.
REQ-003 SHALL have parameter RSP_ACK, default 8'h06, write-complete response byte.
REQ-004 SHALL have parameter RSP_NAK, default 8'h15, error response byte.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT cycles before abort.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port i_rx_data, input, 8, received byte.
REQ-009 SHALL have port i_rx_valid, input, 1, one-cycle strobe, i_rx_data valid.
REQ-010 SHALL have port o_tx_data, output, 8, byte to transmit.
REQ-011 SHALL have port o_tx_valid, output, 1, o_tx_data valid.
REQ-012 SHALL have port i_tx_rdy, input, 1, transmitter accepts a byte.
REQ-013 SHALL have port o_mem_op, output, 2, bus op: 0 NOP, 1 READ, 2 WRITE.
REQ-014 SHALL have port o_mem_addr, output, 64, bus address.
REQ-015 SHALL have port o_mem_data, output, 64, bus write data.
REQ-016 SHALL have port i_mem_data, input, 64, bus read data from responder.
REQ-017 SHALL have port i_mem_op_pending, input, 1, responder busy.
REQ-018 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, RX_ADDR, RX_DATA, ISSUE, WAIT, TX_DATA, TX_RESP.
REQ-020 IDLE: on i_rx_valid with CMD_READ or CMD_WRITE, SHALL latch the op, clear the byte counter, and go to RX_ADDR; with any other byte, SHALL load RSP_NAK and go to TX_RESP.
REQ-021 RX_ADDR SHALL shift in 8 bytes little-endian (byte k into o_mem_addr[8k+7:8k]); after byte 8 it SHALL go to RX_DATA for a write or to ISSUE for a read.
REQ-022 RX_DATA SHALL shift in 8 bytes little-endian into o_mem_data, then go to ISSUE.
REQ-023 In ISSUE, o_mem_op SHALL equal the latched op for exactly one cycle, then the block SHALL go to WAIT; o_mem_op SHALL be NOP in every other state.
REQ-024 o_mem_addr and o_mem_data SHALL remain stable from ISSUE until the block returns to IDLE.
REQ-025 WAIT SHALL last at least one cycle; when i_mem_op_pending==0, a read SHALL capture i_mem_data and go to TX_DATA, and a write SHALL load RSP_ACK and go to TX_RESP.
REQ-026 WAIT SHALL count cycles; if the count reaches TIMEOUT_CYCLES with pending still high, the block SHALL load RSP_NAK and go to TX_RESP, discarding any read data.
REQ-027 TX_DATA SHALL send the 8 captured bytes LSB first, then go to IDLE.
REQ-028 TX_RESP SHALL send one byte, then go to IDLE.
REQ-029 A byte SHALL be transferred on any cycle with o_tx_valid && i_tx_rdy; o_tx_data SHALL be held until that cycle, and the next byte SHALL be presented on the following cycle.
REQ-030 i_rx_valid in ISSUE, WAIT, TX_DATA, or TX_RESP SHALL be ignored, and the byte SHALL be dropped.
REQ-031 Byte counters SHALL be 3-bit and wrap 7->0 only on the state exit.

Reset
REQ-032 On i_rst_n==0 at a clock edge, the block SHALL enter IDLE and clear o_mem_op, o_mem_addr, o_mem_data, o_tx_data, o_tx_valid, o_busy, the counters, and the capture register; this SHALL apply in any state, including mid-frame or WAIT.
REQ-033 After a reset, no partial frame or pending TX byte SHALL be resumed.

Verification
REQ-034 Write: RX 57, addr 10 00 00 00 00 00 00 00, data 88 77 66 55 44 33 22 11 -> one-cycle o_mem_op=2, addr 0x10, data 0x1122334455667788; pending stays 0; TX 06.
REQ-035 Read: RX 52, addr 10 00..00; responder holds pending 2 cycles, then returns 0x1122334455667788 -> o_mem_op=1 for one cycle; TX 88 77 66 55 44 33 22 11.
REQ-036 Bad command: RX 41 -> TX 15; no bus op; o_busy returns to 0.
REQ-037 Timeout: pending held high forever after a read ISSUE -> TX 15 after exactly TIMEOUT_CYCLES WAIT cycles; no data bytes sent.
REQ-038 Backpressure: i_tx_rdy toggled 1-of-3 cycles during a read reply -> all 8 bytes in order, none duplicated or lost, o_tx_data stable while stalled.
REQ-039 Reset mid-op: i_rst_n low after the 4th address byte -> outputs zero; a following full write frame completes with ACK.
